// File: rtl/merge8_sync.sv
// 2-to-1 packet merge for W-bit flits: round-robin head arbitration, the grant is held to the tail flit, and one origin token is emitted per packet.
// Latency: an accepted flit or token is visible on out_valid/s_valid the next cycle when its FIFO was empty; 1 flit/cycle while locked.
// Backpressure: a full out FIFO stalls every input; a full select FIFO stalls only new packet heads; readies never depend on out_ready/s_ready.
module merge8_sync #(
  parameter int W        = 9,
  parameter int TAIL_BIT = W - 1,
  parameter int ODEPTH   = 2,
  parameter int SDEPTH   = 2
) (
  input  logic         CLK,
  input  logic         _RESET,
  input  logic [W-1:0] in0_data,
  input  logic         in0_valid,
  output logic         in0_ready,
  input  logic [W-1:0] in1_data,
  input  logic         in1_valid,
  output logic         in1_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         s_data,
  output logic         s_valid,
  input  logic         s_ready
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t       state, state_nxt;
  logic         rr, rr_nxt;
  logic         any_vld;
  logic         win;
  logic [W-1:0] head_dat;
  logic         head_ok;
  logic         out_push_vld;
  logic [W-1:0] out_push_dat;
  logic         out_push_rdy;
  logic         s_push_vld;
  logic         s_push_rdy;

  // Head arbitration: a lone requester wins outright; on a tie the input
  // that did not win the previous packet goes next.
  assign any_vld  = in0_valid | in1_valid;
  assign win      = (in0_valid & in1_valid) ? ~rr : in1_valid;
  assign head_dat = win ? in1_data : in0_data;
  // A new packet needs room for both its first flit and its origin token.
  // Readies are forced low while reset is held.
  assign head_ok  = _RESET & out_push_rdy & s_push_rdy & any_vld;

  // State and round-robin pointer; the pointer starts at 1 so input 0 wins the first tie.
  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      state <= IDLE;
      rr    <= 1'b1;
    end else begin
      state <= state_nxt;
      rr    <= rr_nxt;
    end
  end

  // Next-state, input readies and FIFO push controls.
  always_comb begin
    state_nxt    = state;
    rr_nxt       = rr;
    in0_ready    = 1'b0;
    in1_ready    = 1'b0;
    out_push_vld = 1'b0;
    out_push_dat = head_dat;
    s_push_vld   = 1'b0;
    case (state)
      IDLE: begin
        if (head_ok) begin
          in0_ready    = ~win;
          in1_ready    = win;
          out_push_vld = 1'b1;
          s_push_vld   = 1'b1;
          rr_nxt       = win;
          if (!head_dat[TAIL_BIT]) begin
            state_nxt = win ? LOCK1 : LOCK0;
          end
        end
      end
      LOCK0: begin
        if (_RESET && out_push_rdy) begin
          in0_ready    = 1'b1;
          out_push_dat = in0_data;
          out_push_vld = in0_valid;
          if (in0_valid && in0_data[TAIL_BIT]) begin
            state_nxt = IDLE;
          end
        end
      end
      LOCK1: begin
        if (_RESET && out_push_rdy) begin
          in1_ready    = 1'b1;
          out_push_dat = in1_data;
          out_push_vld = in1_valid;
          if (in1_valid && in1_data[TAIL_BIT]) begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  merge8_fifo #(.W(W), .DEPTH(ODEPTH)) u_out_fifo (
    .CLK      (CLK),
    ._RESET   (_RESET),
    .push_vld (out_push_vld),
    .push_dat (out_push_dat),
    .push_rdy (out_push_rdy),
    .pop_vld  (out_valid),
    .pop_dat  (out_data),
    .pop_rdy  (out_ready)
  );

  merge8_fifo #(.W(1), .DEPTH(SDEPTH)) u_s_fifo (
    .CLK      (CLK),
    ._RESET   (_RESET),
    .push_vld (s_push_vld),
    .push_dat (win),
    .push_rdy (s_push_rdy),
    .pop_vld  (s_valid),
    .pop_dat  (s_data),
    .pop_rdy  (s_ready)
  );

endmodule

// Generic synchronous FIFO with registered storage and occupancy counter.
// Latency: a pushed entry is visible on pop_vld the cycle after the push when empty.
// Backpressure: push_rdy low at full, even if a pop happens the same cycle.
module merge8_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 2
) (
  input  logic         CLK,
  input  logic         _RESET,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  output logic         push_rdy,
  output logic         pop_vld,
  output logic [W-1:0] pop_dat,
  input  logic         pop_rdy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  // Pointers wrap modulo DEPTH so non power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign push_rdy = (count < CW'(DEPTH));
  assign pop_vld  = (count != '0);
  assign pop_dat  = mem[rd_ptr];
  assign do_push  = push_vld & push_rdy;
  assign do_pop   = pop_vld & pop_rdy;

  // Pointer and occupancy update; push+pop together leaves count unchanged.
  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (!do_push && do_pop) begin
        count <= count - CW'(1);
      end
    end
  end

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

endmodule

// File: doc/merge8_sync.md
Name: merge8_sync

Overview:
- Clocked 2-to-1 packet merge for 9-bit flits; the converging counterpart of the 1-to-2 decoder8 router stage.
- Arbitrates two input flit channels onto one output channel, holding the grant for a whole packet until its tail flit.
- Reports the winning input index once per packet on a 1-bit S channel so downstream can reconstruct origin.
- Sits at the clocked boundary of the NoC; valid/ready handshakes on every channel.

Parameters:
- W, 9, flit width in bits.
- TAIL_BIT, W-1, flit bit index that marks the tail flit (1 = last flit of packet).
- ODEPTH, 2, output flit FIFO depth (>=2).
- SDEPTH, 2, select-token FIFO depth (>=1).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- _RESET  in  1  asynchronous active-low reset.
- in0_data  in  W  flit from input 0.
- in0_valid  in  1  input 0 flit present.
- in0_ready  out  1  input 0 flit accepted this cycle when valid is also high.
- in1_data, in1_valid, in1_ready  as input 0, for input 1.
- out_data  out  W  merged flit.
- out_valid  out  1  out_data present.
- out_ready  in  1  downstream accepts out_data.
- s_data  out  1  index of the input granted for a packet.
- s_valid  out  1  select token present.
- s_ready  in  1  downstream accepts the select token.

Behaviour:
- Reset (_RESET low, async): state=IDLE; both FIFOs emptied; out_valid=0, s_valid=0, in0_ready=in1_ready=0; rr pointer=1, so input 0 wins the first tie. In-flight packets are discarded, with no partial output after release.
- Handshake: a transfer occurs when valid&ready are high at a rising CLK edge. Upstream holds data stable while valid&!ready. The block holds out_data/s_data stable while valid&!ready.
- in*_ready depends only on state, FIFO occupancy and in*_valid. It never depends combinationally on out_ready or s_ready.
- FSM states: IDLE, LOCK0, LOCK1.
- IDLE:
  - A grant is possible if out FIFO count<ODEPTH and S FIFO count<SDEPTH.
  - Winner: the single valid input, or on a tie the input != rr pointer.
  - The winner's ready=1 and the loser's ready=0.
  - On transfer: push flit to out FIFO, push winner index to S FIFO, rr<=winner.
  - Next state: if flit[TAIL_BIT]=1, stay IDLE (single-flit packet); else go to LOCKn.
- LOCKn:
  - inn_ready = (out FIFO count<ODEPTH). The other input's ready=0.
  - No S push.
  - On transfer of a flit with TAIL_BIT=1, return to IDLE; the next grant is no earlier than the following cycle.
- Latency: an accepted flit appears on out_valid the next cycle when the FIFO was empty. The same applies to the S token. Throughput is 1 flit/cycle in LOCK with out_ready=1.
- FIFOs:
  - Push is allowed only when count<DEPTH; a full FIFO does not push even if popping the same cycle.
  - Simultaneous push/pop leaves count unchanged.
  - Order is preserved; pointers wrap modulo DEPTH.
- Boundaries:
  - A full out FIFO blocks every input.
  - A full S FIFO blocks only new heads; LOCK traffic continues.
  - Idle inputs with valid low have no effect on the rr pointer.

Test Plan:
- Single flit: in0 sends 0x1A5 (tail) with out_ready=s_ready=1 -> next cycle out_data=0x1A5, s_data=0, both valid for one cycle.
- Contention: in0 and in1 both continuously offer single-flit packets 0x100 and 0x101 -> out alternates 0x100,0x101,0x100,0x101; s_data 0,1,0,1.
- Packet lock: in0 sends 0x011,0x022,0x1FF while in1 holds 0x155 valid -> out order 0x011,0x022,0x1FF,0x155; exactly one S token each (0 then 1); in1_ready=0 until the cycle after the tail is accepted.
- Out backpressure: out_ready=0 while in0 streams a 4-flit packet -> in0_ready drops after 2 flits; raise out_ready -> all 4 flits delivered in order, no loss or duplicates.
- S backpressure: s_ready=0, out_ready=1, in1 sends three single-flit packets -> first two accepted, third held with in1_ready=0; s_ready=1 -> third accepted, tokens 1,1,1.
- Reset mid-packet: pull _RESET low in LOCK0 after 2 of 3 flits -> out_valid/s_valid go 0 immediately. After release, in1 0x1AA is granted with s_data=1, and no leftover in0 flits appear.
